// File: rtl/host_cmd_pkg.sv
// Purpose: shared types and header field layout for the host command parser.
// Latency: n/a (types, constants and decode helpers only).
// Backpressure: n/a.
package host_cmd_pkg;

    // Header word layout: [31:24] opcode, [23:20] argument count, [19:0] ignored
    localparam int HDR_OPCODE_LSB = 24;
    localparam int HDR_OPCODE_W   = 8;
    localparam int HDR_NARGS_LSB  = 20;
    localparam int HDR_NARGS_W    = 4;

    // Bit positions inside the sticky error vector
    localparam int ERR_BAD_LEN = 0;
    localparam int ERR_TIMEOUT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        ARGS = 1'b1
    } parser_state_e;

    typedef logic [HDR_OPCODE_W-1:0] opcode_t;
    typedef logic [HDR_NARGS_W-1:0]  nargs_t;

    function automatic opcode_t hdr_opcode(input logic [31:0] word);
        return word[HDR_OPCODE_LSB +: HDR_OPCODE_W];
    endfunction

    function automatic nargs_t hdr_nargs(input logic [31:0] word);
        return word[HDR_NARGS_LSB +: HDR_NARGS_W];
    endfunction

    // Width of one queued command record for a given argument capacity
    function automatic int cmd_rec_bits(input int max_args);
        return HDR_OPCODE_W + HDR_NARGS_W + 32 * max_args;
    endfunction

endpackage

// File: rtl/host_cmd_parser_if.sv
// Purpose: bundles the driver word stream and the command delivery handshake.
// Latency: n/a (wiring only).
// Backpressure: host_wr_ready stalls the driver; cmd_ready stalls command delivery.
interface host_cmd_parser_if #(
    parameter int DEPTH    = 4,
    parameter int MAX_ARGS = 3
);
    logic                       host_wr_en;
    logic [31:0]                host_wr_data;
    logic                       host_wr_ready;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [7:0]                 cmd_opcode;
    logic [3:0]                 cmd_nargs;
    logic [32*MAX_ARGS-1:0]     cmd_args;
    logic [$clog2(DEPTH):0]     cmd_count;
    logic [1:0]                 err;
    logic                       err_clr;

    // Driver / controller side
    modport master (
        output host_wr_en, host_wr_data, cmd_ready, err_clr,
        input  host_wr_ready, cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_count, err
    );

    // Parser side
    modport slave (
        input  host_wr_en, host_wr_data, cmd_ready, err_clr,
        output host_wr_ready, cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_count, err
    );
endinterface

// File: rtl/host_cmd_queue.sv
// Purpose: synchronous FIFO of complete command records.
// Latency: an entry pushed on one edge is visible at pop_dat after that edge; no bypass.
// Backpressure: pushes while full and pops while empty are ignored; caller gates on count.
module host_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head entry is forced to zero while empty so a freshly reset queue shows clean fields
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Entry storage; contents are don't-care until written, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks push minus pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/host_cmd_parser.sv
// Purpose: frames the raw driver word stream into header+argument commands and queues them.
// Latency: command appears on cmd_valid the cycle after its last word is accepted.
// Backpressure: host_wr_ready drops while the queue is full; no pop-through. Optional HOST_CMD_TIMEOUT_EN.
module host_cmd_parser
    import host_cmd_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int MAX_ARGS       = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    host_cmd_parser_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ARG_W = 32 * MAX_ARGS;

    typedef struct packed {
        opcode_t            opcode;
        nargs_t             nargs;
        logic [ARG_W-1:0]   args;
    } cmd_rec_t;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_ARGS < 1 || MAX_ARGS > 15
            || TIMEOUT_CYCLES < 1 || $bits(cmd_rec_t) != cmd_rec_bits(MAX_ARGS)) begin : g_bad_param
            $error("host_cmd_parser: illegal parameter combination");
        end
    endgenerate

    parser_state_e    state;
    parser_state_e    state_nxt;
    parser_state_e    dec_state;
    opcode_t          hdr_op;
    nargs_t           hdr_na;
    opcode_t          cur_op;
    nargs_t           cur_na;
    nargs_t           argidx;
    logic [ARG_W-1:0] arg_buf;
    logic             last_arg;
    logic             accept;
    logic             full;
    logic             push;
    logic             pop;
    logic             latch_hdr;
    logic             store_arg;
    logic             timeout_hit;
    logic [1:0]       err_set;
    logic [1:0]       err_q;
    logic [CNT_W-1:0] count;
    cmd_rec_t         push_rec;
    cmd_rec_t         head_rec;

    assign full              = (count == CNT_W'(DEPTH));
    assign accept            = bus.host_wr_en && !full;
    assign pop               = bus.cmd_valid && bus.cmd_ready;
    assign hdr_op            = hdr_opcode(bus.host_wr_data);
    assign hdr_na            = hdr_nargs(bus.host_wr_data);
    assign last_arg          = (argidx == cur_na - 4'd1);

    // A timeout abandons the partial command; a word in that cycle is decoded as a header
    assign dec_state         = timeout_hit ? IDLE : state;

    assign bus.host_wr_ready = !full;
    assign bus.cmd_valid     = (count != '0);
    assign bus.cmd_count     = count;
    assign bus.cmd_opcode    = head_rec.opcode;
    assign bus.cmd_nargs     = head_rec.nargs;
    assign bus.cmd_args      = head_rec.args;
    assign bus.err           = err_q;

`ifdef HOST_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign timeout_hit = (state == ARGS) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    // Count idle cycles spent waiting for argument words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept || timeout_hit || state != ARGS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Framer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Framer next-state: headers with 1..MAX_ARGS args open a frame, last arg closes it
    always_comb begin
        state_nxt = dec_state;
        if (accept) begin
            case (dec_state)
                IDLE: if (hdr_na != '0 && hdr_na <= nargs_t'(MAX_ARGS)) state_nxt = ARGS;
                ARGS: if (last_arg) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Framer outputs: queue push, record assembly, header latch, error pulses
    always_comb begin
        push      = 1'b0;
        push_rec  = '0;
        latch_hdr = 1'b0;
        store_arg = 1'b0;
        err_set   = '0;
        if (timeout_hit) err_set[ERR_TIMEOUT] = 1'b1;
        if (accept) begin
            case (dec_state)
                IDLE: begin
                    if (hdr_na == '0) begin
                        push            = 1'b1;
                        push_rec.opcode = hdr_op;
                    end else if (hdr_na > nargs_t'(MAX_ARGS)) begin
                        err_set[ERR_BAD_LEN] = 1'b1;
                    end else begin
                        latch_hdr = 1'b1;
                    end
                end
                ARGS: begin
                    store_arg = 1'b1;
                    if (last_arg) begin
                        push            = 1'b1;
                        push_rec.opcode = cur_op;
                        push_rec.nargs  = cur_na;
                        push_rec.args   = arg_buf;
                        for (int i = 0; i < MAX_ARGS; i++) begin
                            if (argidx == nargs_t'(i)) push_rec.args[32*i +: 32] = bus.host_wr_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Partial command buffer: header fields plus argument words collected so far
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_op  <= '0;
            cur_na  <= '0;
            argidx  <= '0;
            arg_buf <= '0;
        end else if (latch_hdr) begin
            cur_op  <= hdr_op;
            cur_na  <= hdr_na;
            argidx  <= '0;
            arg_buf <= '0;
        end else if (store_arg) begin
            for (int i = 0; i < MAX_ARGS; i++) begin
                if (argidx == nargs_t'(i)) arg_buf[32*i +: 32] <= bus.host_wr_data;
            end
            argidx <= argidx + 4'd1;
        end
    end

    // Sticky errors; a new error in the clear cycle survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= (bus.err_clr ? 2'b00 : err_q) | err_set;
        end
    end

    host_cmd_queue #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_rec_t))
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_rec),
        .pop      (pop),
        .pop_dat  (head_rec),
        .count    (count)
    );

endmodule
